sd_dat_rx: RTL and testbench
============================

# sd_dat_rx

Receive-side data-path engine for the SD card 4-bit DAT bus. When armed it waits for a start bit and deserialises one data block into bytes. It checks a per-line CRC16 (x^16 + x^12 + x^5 + 1, zero init, MSB first) against the 16 CRC bits sent by the card, then checks the end bit. It sits in the data driver beside the transmit-side CRC16 generator and feeds received bytes to the downstream buffer/cipher logic.

## Interface
Parameters:
- BLOCK_BYTES, 512, bytes per block (≥1); nibble count NN = 2*BLOCK_BYTES
- TIMEOUT, 65535, max iclk cycles spent waiting for the start bit (≥1)

Ports:
- iclk  in  1  SD clock; DAT lines sampled on rising edge
- irst  in  1  reset irst, asynchronous, active-high; clock iclk
- istart  in  1  one-cycle arm pulse; honoured only in IDLE
- idat  in  4  DAT[3:0] from pads, already synchronous to iclk
- odata  out  8  received byte, DAT3 of first nibble = bit 7
- ovalid  out  1  one-cycle strobe, odata valid
- obusy  out  1  high in every state except IDLE
- odone  out  1  one-cycle pulse, end of transfer or timeout
- ocrc_err  out  1  CRC mismatch on any line; valid at odone, held until next accepted istart
- oend_err  out  1  end bit not all-ones; same validity/hold as ocrc_err
- otimeout  out  1  start bit never seen; same validity/hold as ocrc_err

## Operation
- States: IDLE, WAIT_START, DATA, CRC, END.
- IDLE: accepting istart clears the four CRC registers, the counters and the three error flags, then enters WAIT_START.
- WAIT_START: start bit = idat == 4'b0000. Partial low (some lines 0) does not count and the block keeps waiting.
  - A timeout counter (width clog2(TIMEOUT+1)) increments each cycle. Reaching TIMEOUT sets otimeout, pulses odone and returns to IDLE.
- DATA: NN edges, one nibble per edge; a nibble counter (width clog2(NN)) counts them.
  - Line n feeds CRC register n: fb = idat[n] ^ crc[15]; shift left; bit0 = fb; bits 5 and 12 get fb ^ previous bit.
  - Even nibble index = high nibble, held in a register. Odd index = low nibble; that edge registers odata = {high, idat} and ovalid.
  - The counter reaching NN-1 moves the FSM to CRC.
- CRC: 16 edges, 4-bit counter.
  - For each line, idat[n] is compared to crc_n[15]. Any mismatch sets the sticky ocrc_err.
  - Each register then shifts left with zero fill and no feedback.
- END: one edge. idat != 4'b1111 sets oend_err. odone pulses; return to IDLE.
- istart outside IDLE is ignored. A new istart may be accepted in the cycle odone is high (the FSM is already in IDLE).
- Reset at any time: FSM to IDLE, all counters and CRC registers 0, all outputs 0. A partially received block is discarded with no odone.

## Timing
- Reset values: odata=0, ovalid=0, obusy=0, odone=0, ocrc_err=0, oend_err=0, otimeout=0.
- All outputs are registered.
- istart sampled at edge s: obusy high from cycle s+1. The earliest start-bit sample is edge s+1.
- Start bit sampled at edge k:
  - Data nibbles are at edges k+1 … k+NN.
  - Byte j (0-based) has ovalid high in the cycle after edge k+2j+2.
  - CRC bits are at edges k+NN+1 … k+NN+16.
  - The end bit is at edge k+NN+17.
  - odone and the final flags are high in the cycle after edge k+NN+17. obusy goes low in that same cycle.
- Timeout: with no start bit, odone and otimeout are high in the cycle after edge s+TIMEOUT.
- ovalid never fires in consecutive cycles; the minimum gap is 1 cycle.
- Throughput: 1 byte per 2 iclk.

## Test plan
- Reset mid-DATA at byte 3 → all outputs 0 next cycle, no odone; a following istart with a clean block completes normally.
- BLOCK_BYTES=4, data 0xA5,0x3C,0xFF,0x00, CRC bits from a bench reference model, end bits 1111:
  - Exactly 4 ovalid strobes carrying those bytes, 2 cycles apart.
  - odone exactly 26 cycles after the start-bit edge (NN+17 edges later, then one output cycle), with all three flags 0.
- All-zero block, CRC 0x0000 on every line → odone, ocrc_err=0. Flip CRC bit 7 on DAT2 only → ocrc_err=1, oend_err=0.
- Valid block with end nibble 4'b1101 → oend_err=1, ocrc_err=0; the flag is held until the next istart and cleared at that accept.
- TIMEOUT=20, idat held at 1111 (and separately at 1110) → no ovalid; odone and otimeout high in the cycle after edge s+20.
- istart pulsed during DATA → ignored, byte count and odone timing unchanged; istart in the odone cycle is accepted (obusy high next cycle).

Source files
------------

// File: rtl/sd_dat_rx_if.sv
// DAT-bus receive handshake between the SD data driver and sd_dat_rx.
// Signal names match the original flat port list of sd_dat_rx.
interface sd_dat_rx_if;
  logic       istart;
  logic [3:0] idat;
  logic [7:0] odata;
  logic       ovalid;
  logic       obusy;
  logic       odone;
  logic       ocrc_err;
  logic       oend_err;
  logic       otimeout;

  modport master (
    output istart, idat,
    input  odata, ovalid, obusy, odone, ocrc_err, oend_err, otimeout
  );

  modport slave (
    input  istart, idat,
    output odata, ovalid, obusy, odone, ocrc_err, oend_err, otimeout
  );
endinterface

// File: rtl/sd_dat_rx.sv
// SD 4-bit DAT receive engine: start-bit hunt, nibble-to-byte deserialisation,
// per-line CRC16 check (x^16+x^12+x^5+1) and end-bit check.
module sd_dat_rx #(
  parameter int unsigned BLOCK_BYTES = 512,
  parameter int unsigned TIMEOUT     = 65535
) (
  input  logic        iclk,
  input  logic        irst,
  sd_dat_rx_if.slave  bus
);

  localparam int unsigned NN = 2 * BLOCK_BYTES;
  localparam int unsigned NW = $clog2(NN);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [NW-1:0] NLAST = NW'(NN - 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, WAIT_START, DATA, CRC, END} state_t;

  state_t          state, state_next;
  logic [TW-1:0]   tcnt;
  logic [NW-1:0]   ncnt;
  logic [3:0]      ccnt;
  logic [3:0][15:0] crc;
  logic [3:0]      high_nib;

  logic clr, wait_tick, tmo, dat_shift, crc_shift, end_chk, crc_mism;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic d);
    logic fb;
    logic [15:0] n;
    fb    = d ^ c[15];
    n     = {c[14:0], fb};
    n[5]  = c[4]  ^ fb;
    n[12] = c[11] ^ fb;
    return n;
  endfunction

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:       if (bus.istart) state_next = WAIT_START;
      WAIT_START: begin
        if (bus.idat == 4'b0000) state_next = DATA;
        else if (tcnt == TLAST)  state_next = IDLE;
      end
      DATA:       if (ncnt == NLAST) state_next = CRC;
      CRC:        if (ccnt == 4'hF)  state_next = END;
      END:        state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  // Decode per-state datapath actions; a start bit wins over a coincident timeout.
  always_comb begin
    clr       = (state == IDLE) && bus.istart;
    wait_tick = (state == WAIT_START);
    tmo       = (state == WAIT_START) && (bus.idat != 4'b0000) && (tcnt == TLAST);
    dat_shift = (state == DATA);
    crc_shift = (state == CRC);
    end_chk   = (state == END);
    crc_mism  = 1'b0;
    for (int unsigned n = 0; n < 4; n++)
      crc_mism = crc_mism | (bus.idat[n] ^ crc[n][15]);
  end

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      tcnt         <= '0;
      ncnt         <= '0;
      ccnt         <= '0;
      crc          <= '0;
      high_nib     <= '0;
      bus.odata    <= '0;
      bus.ovalid   <= 1'b0;
      bus.obusy    <= 1'b0;
      bus.odone    <= 1'b0;
      bus.ocrc_err <= 1'b0;
      bus.oend_err <= 1'b0;
      bus.otimeout <= 1'b0;
    end else begin
      bus.ovalid <= 1'b0;
      bus.odone  <= 1'b0;
      bus.obusy  <= (state_next != IDLE);

      if (clr) begin
        tcnt         <= '0;
        ncnt         <= '0;
        ccnt         <= '0;
        crc          <= '0;
        bus.ocrc_err <= 1'b0;
        bus.oend_err <= 1'b0;
        bus.otimeout <= 1'b0;
      end

      if (wait_tick) tcnt <= tcnt + TW'(1);
      if (tmo) begin
        bus.otimeout <= 1'b1;
        bus.odone    <= 1'b1;
      end

      if (dat_shift) begin
        for (int unsigned n = 0; n < 4; n++)
          crc[n] <= crc_step(crc[n], bus.idat[n]);
        ncnt <= ncnt + NW'(1);
        if (!ncnt[0]) begin
          high_nib <= bus.idat;
        end else begin
          bus.odata  <= {high_nib, bus.idat};
          bus.ovalid <= 1'b1;
        end
      end

      // Received CRC bits are compared against the MSB, then shifted out.
      if (crc_shift) begin
        if (crc_mism) bus.ocrc_err <= 1'b1;
        for (int unsigned n = 0; n < 4; n++)
          crc[n] <= {crc[n][14:0], 1'b0};
        ccnt <= ccnt + 4'd1;
      end

      if (end_chk) begin
        if (bus.idat != 4'b1111) bus.oend_err <= 1'b1;
        bus.odone <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sd_dat_rx.sv
// Self-checking bench for sd_dat_rx with BLOCK_BYTES=4, TIMEOUT=20; CRCs come
// from a bitwise polynomial-division model of each DAT line.
module tb_sd_dat_rx;

  localparam int unsigned BB = 4;
  localparam int unsigned NN = 2 * BB;
  localparam int unsigned TO = 20;

  logic iclk = 1'b0;
  logic irst;
  always #5 iclk = ~iclk;

  sd_dat_rx_if bus ();

  sd_dat_rx #(.BLOCK_BYTES(BB), .TIMEOUT(TO)) dut (
    .iclk (iclk),
    .irst (irst),
    .bus  (bus)
  );

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge iclk);
    #1;
  endtask

  // Line bit stream = bit <line> of each nibble, first nibble first.
  function automatic logic [15:0] ref_crc(input logic [31:0] blk, input int line);
    logic [15:0] c;
    logic        top;
    c = '0;
    for (int i = 0; i < int'(NN); i++) begin
      top = c[15] ^ blk[28 - 4*i + line];
      c   = c << 1;
      if (top) c = c ^ 16'h1021;
    end
    return c;
  endfunction

  task automatic run_block(input logic [31:0] blk, input int wait_n,
                           input int flip_line, input int flip_bit,
                           input logic [3:0] end_nib, input int pulse_at,
                           input int reset_at);
    logic [15:0] c [4];
    for (int n = 0; n < 4; n++) c[n] = ref_crc(blk, n);
    if (flip_line >= 0) c[flip_line][flip_bit] = ~c[flip_line][flip_bit];

    bus.istart = 1'b1;
    bus.idat   = 4'hF;
    tick();
    bus.istart = 1'b0;
    chk("busy_after_accept", bus.obusy, 1);
    chk("crc_err_cleared", bus.ocrc_err, 0);
    chk("end_err_cleared", bus.oend_err, 0);
    chk("timeout_cleared", bus.otimeout, 0);

    for (int w = 0; w < wait_n; w++) begin
      bus.idat = 4'($urandom_range(1, 15));
      tick();
      chk("no_done_waiting", bus.odone, 0);
    end
    bus.idat = 4'h0;
    tick();

    for (int i = 0; i < int'(NN); i++) begin
      bus.idat   = blk[31 - 4*i -: 4];
      bus.istart = (i == pulse_at);
      tick();
      bus.istart = 1'b0;
      if (i == reset_at) begin
        irst = 1'b1;
        #1;
        chk("rst_odata", bus.odata, 0);
        chk("rst_ovalid", bus.ovalid, 0);
        chk("rst_obusy", bus.obusy, 0);
        chk("rst_odone", bus.odone, 0);
        @(negedge iclk);
        irst = 1'b0;
        bus.idat = 4'hF;
        for (int k = 0; k < 30; k++) begin
          tick();
          chk("no_done_after_rst", bus.odone, 0);
        end
        return;
      end
      chk("ovalid", bus.ovalid, 32'(i % 2));
      if (i % 2 == 1) chk("odata", bus.odata, blk[31 - 8*(i/2) -: 8]);
    end

    for (int b = 0; b < 16; b++) begin
      for (int n = 0; n < 4; n++) bus.idat[n] = c[n][15 - b];
      tick();
      if (b == 0 || b == 15) begin
        chk("crc_phase_done", bus.odone, 0);
        chk("crc_phase_valid", bus.ovalid, 0);
        chk("crc_phase_busy", bus.obusy, 1);
      end
    end

    bus.idat = end_nib;
    tick();
    bus.idat = 4'hF;
    chk("odone", bus.odone, 1);
    chk("busy_at_done", bus.obusy, 0);
    chk("crc_err", bus.ocrc_err, 32'(flip_line >= 0));
    chk("end_err", bus.oend_err, 32'(end_nib != 4'hF));
    chk("timeout_at_done", bus.otimeout, 0);
  endtask

  task automatic hold_check(input logic exp_crc, input logic exp_end);
    tick();
    chk("done_one_cycle", bus.odone, 0);
    chk("crc_err_held", bus.ocrc_err, 32'(exp_crc));
    chk("end_err_held", bus.oend_err, 32'(exp_end));
  endtask

  task automatic timeout_run(input logic [3:0] nib, input bit armed);
    if (!armed) begin
      bus.istart = 1'b1;
      bus.idat   = nib;
      tick();
      bus.istart = 1'b0;
      chk("tmo_busy", bus.obusy, 1);
    end
    for (int m = 1; m <= int'(TO); m++) begin
      bus.idat = nib;
      tick();
      chk("tmo_no_valid", bus.ovalid, 0);
      if (m < int'(TO)) begin
        chk("tmo_early_done", bus.odone, 0);
      end else begin
        chk("tmo_done", bus.odone, 1);
        chk("tmo_flag", bus.otimeout, 1);
        chk("tmo_busy_low", bus.obusy, 0);
        chk("tmo_crc_err", bus.ocrc_err, 0);
      end
    end
    bus.idat = 4'hF;
    tick();
    chk("tmo_flag_held", bus.otimeout, 1);
  endtask

  initial begin
    logic [31:0] blk;
    int          fl;
    logic [3:0]  en;

    irst       = 1'b1;
    bus.istart = 1'b0;
    bus.idat   = 4'hF;
    #12;
    chk("reset_odata", bus.odata, 0);
    chk("reset_ovalid", bus.ovalid, 0);
    chk("reset_obusy", bus.obusy, 0);
    chk("reset_odone", bus.odone, 0);
    chk("reset_crc_err", bus.ocrc_err, 0);
    chk("reset_end_err", bus.oend_err, 0);
    chk("reset_timeout", bus.otimeout, 0);
    @(negedge iclk);
    irst = 1'b0;
    tick();

    run_block(32'hA53CFF00, 3, -1, 0, 4'hF, -1, -1);
    hold_check(1'b0, 1'b0);

    run_block(32'h0000_0000, 0, -1, 0, 4'hF, -1, -1);
    hold_check(1'b0, 1'b0);
    run_block(32'h0000_0000, 2, 2, 7, 4'hF, -1, -1);
    hold_check(1'b1, 1'b0);

    run_block($urandom, 1, -1, 0, 4'b1101, -1, -1);
    hold_check(1'b0, 1'b1);
    hold_check(1'b0, 1'b1);
    run_block($urandom, 4, -1, 0, 4'hF, 3, -1);
    hold_check(1'b0, 1'b0);

    run_block($urandom, 2, -1, 0, 4'hF, -1, 6);
    run_block($urandom, 5, -1, 0, 4'hF, -1, -1);
    hold_check(1'b0, 1'b0);

    timeout_run(4'b1111, 1'b0);
    timeout_run(4'b1110, 1'b0);

    for (int r = 0; r < 6; r++) begin
      blk = $urandom;
      fl  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : -1;
      en  = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom_range(0, 14));
      run_block(blk, int'($urandom_range(0, 10)), fl, int'($urandom_range(0, 15)),
                en, -1, -1);
      hold_check(fl >= 0, en != 4'hF);
    end

    run_block($urandom, 0, -1, 0, 4'hF, -1, -1);
    bus.istart = 1'b1;
    bus.idat   = 4'hF;
    tick();
    bus.istart = 1'b0;
    chk("accept_in_done_cycle", bus.obusy, 1);
    timeout_run(4'hF, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
